// File: rtl/permutation_round_ctrl.sv
// Iteration controller and state register for the ASCON permutation.
// Ports:
//   clock_i        system clock, rising edge
//   reset_i        synchronous reset, active high
//   start_i        start request, sampled in IDLE only
//   rounds_sel_i   0 = p12, 1 = p6, sampled with start_i
//   state_init_i   initial 320-bit state, sampled with start_i
//   round_state_o  state register, to the constant-addition stage
//   round_o        round index, to the constant-addition stage
//   round_state_i  round datapath result
//   state_o        permutation result (state register)
//   busy_o         high while rounds are being applied
//   done_o         one-cycle pulse when state_o holds the final result
module permutation_round_ctrl #(
  parameter int unsigned NB_ROUNDS_FULL  = 12,
  parameter int unsigned NB_ROUNDS_SHORT = 6
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic         rounds_sel_i,
  input  logic [319:0] state_init_i,
  output logic [319:0] round_state_o,
  output logic [3:0]   round_o,
  input  logic [319:0] round_state_i,
  output logic [319:0] state_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam logic [3:0] LAST_ROUND  = 4'(NB_ROUNDS_FULL - 1);
  localparam logic [3:0] FIRST_SHORT = 4'(NB_ROUNDS_FULL - NB_ROUNDS_SHORT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t         r_fsm;
  state_t         w_fsm_next;
  logic [319:0]   r_state_reg;
  logic [319:0]   w_state_next;
  logic [3:0]     r_round_cnt;
  logic [3:0]     w_cnt_next;
  logic           w_busy;
  logic           w_done;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_fsm       <= ST_IDLE;
      r_state_reg <= '0;
      r_round_cnt <= '0;
    end else begin
      r_fsm       <= w_fsm_next;
      r_state_reg <= w_state_next;
      r_round_cnt <= w_cnt_next;
    end
  end

  always_comb begin
    w_fsm_next   = r_fsm;
    w_state_next = r_state_reg;
    w_cnt_next   = r_round_cnt;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_fsm)
      ST_IDLE: begin
        if (start_i) begin
          w_state_next = state_init_i;
          w_cnt_next   = rounds_sel_i ? FIRST_SHORT : '0;
          w_fsm_next   = ST_RUN;
        end
      end
      ST_RUN: begin
        w_busy       = 1'b1;
        w_state_next = round_state_i;
        if (r_round_cnt == LAST_ROUND) begin
          w_cnt_next = '0;
          w_fsm_next = ST_DONE;
        end else begin
          w_cnt_next = r_round_cnt + 4'd1;
        end
      end
      ST_DONE: begin
        // start_i is deliberately not looked at here; a start in this cycle is lost
        w_done     = 1'b1;
        w_fsm_next = ST_IDLE;
      end
      default: begin
        w_fsm_next = ST_IDLE;
      end
    endcase
  end

  assign round_state_o = r_state_reg;
  assign state_o       = r_state_reg;
  assign round_o       = r_round_cnt;
  assign busy_o        = w_busy;
  assign done_o        = w_done;

endmodule
